// File: rtl/keypad_scanner.sv
// keypad_scanner: 4x4 active-low keypad front end.
// Rotates the row strobes, samples synchronised columns once per row dwell,
// classifies each full scan as EMPTY / SINGLE(K) / MULTI, debounces over
// whole scans, rejects ghost presses and emits one-cycle key events.
// Optional build macro: KEYPAD_REPEAT_EN adds auto-repeat while a key is held.
//
// state        | meaning
// IDLE         | no key accepted, waiting for a single-key scan
// DEBOUNCE     | counting consecutive identical single-key scans
// PRESSED      | key accepted and still held (key_held=1)
// WAIT_RELEASE | ambiguous or stale input, waiting for an empty scan
module keypad_scanner #(
  parameter int SCAN_DIV       = 1000000,
  parameter int DEBOUNCE_SCANS = 3,
  parameter int REPEAT_SCANS   = 20
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       enable,
  input  logic [3:0] keypadCol,
  output logic [3:0] keypadRow,
  output logic       key_valid,
  output logic [3:0] key_code,
  output logic       key_held
);

  localparam int DIV_W   = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  // One scan counter serves both debounce and repeat; they never overlap.
  localparam int CNT_MAX = (DEBOUNCE_SCANS > REPEAT_SCANS) ? DEBOUNCE_SCANS : REPEAT_SCANS;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_SCANS - 1);
`ifdef KEYPAD_REPEAT_EN
  localparam logic [CNT_W-1:0] RPT_LAST = CNT_W'(REPEAT_SCANS - 1);
`endif

  typedef enum logic [1:0] {
    IDLE,
    DEBOUNCE,
    PRESSED,
    WAIT_RELEASE
  } state_t;

  state_t             state;
  logic [3:0]         col_meta;
  logic [3:0]         col_sync;
  logic [DIV_W-1:0]   div_cnt;
  logic               tick;
  logic [1:0]         row_idx;
  logic               row_legal;
  logic [1:0]         col_idx;
  logic [1:0]         row_hits;   // 0, 1, or 2 meaning "two or more"
  logic [1:0]         acc_hits;
  logic [3:0]         acc_key;
  logic [2:0]         hit_sum;
  logic [1:0]         scan_hits;
  logic [3:0]         scan_key;
  logic               scan_done;
  logic               scan_empty;
  logic               scan_single;
  logic [3:0]         cand;
  logic [CNT_W-1:0]   scan_cnt;

  // Two-flop synchroniser for the asynchronous column returns.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      col_meta <= 4'b1111;
      col_sync <= 4'b1111;
    end else begin
      col_meta <= keypadCol;
      col_sync <= col_meta;
    end
  end

  assign tick = (div_cnt == DIV_LAST);

  // Row dwell divider, 0..SCAN_DIV-1.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      div_cnt <= '0;
    end else if (tick) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + DIV_W'(1);
    end
  end

  // Decode which row is currently strobed.
  always_comb begin
    row_idx   = 2'd0;
    row_legal = 1'b1;
    case (keypadRow)
      4'b1110: row_idx = 2'd0;
      4'b1101: row_idx = 2'd1;
      4'b1011: row_idx = 2'd2;
      4'b0111: row_idx = 2'd3;
      default: row_legal = 1'b0;
    endcase
  end

  // Classify the synchronised column sample for the current row.
  always_comb begin
    col_idx  = 2'd0;
    row_hits = 2'd2;
    case (col_sync)
      4'b1111: row_hits = 2'd0;
      4'b1110: begin row_hits = 2'd1; col_idx = 2'd0; end
      4'b1101: begin row_hits = 2'd1; col_idx = 2'd1; end
      4'b1011: begin row_hits = 2'd1; col_idx = 2'd2; end
      4'b0111: begin row_hits = 2'd1; col_idx = 2'd3; end
      default: row_hits = 2'd2;
    endcase
  end

  // Merge this row's sample into the running scan result.
  always_comb begin
    hit_sum   = {1'b0, acc_hits} + {1'b0, row_hits};
    scan_hits = (hit_sum > 3'd1) ? 2'd2 : hit_sum[1:0];
    scan_key  = (acc_hits == 2'd0) ? {row_idx, col_idx} : acc_key;
  end

  assign scan_done   = tick && row_legal && (row_idx == 2'd3);
  assign scan_empty  = (scan_hits == 2'd0);
  assign scan_single = (scan_hits == 2'd1);

  // Row rotation and per-scan accumulation, both advanced on tick.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      keypadRow <= 4'b1110;
      acc_hits  <= 2'd0;
      acc_key   <= 4'd0;
    end else if (tick) begin
      case (keypadRow)
        4'b1110: keypadRow <= 4'b1101;
        4'b1101: keypadRow <= 4'b1011;
        4'b1011: keypadRow <= 4'b0111;
        default: keypadRow <= 4'b1110;
      endcase
      // An illegal row restarts the scan from row 0 with a clean result.
      if (!row_legal || row_idx == 2'd3) begin
        acc_hits <= 2'd0;
        acc_key  <= 4'd0;
      end else begin
        acc_hits <= scan_hits;
        acc_key  <= scan_key;
      end
    end
  end

  // Press/release state machine, evaluated once per completed scan.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      key_valid <= 1'b0;
      key_code  <= 4'd0;
      key_held  <= 1'b0;
      cand      <= 4'd0;
      scan_cnt  <= '0;
    end else begin
      key_valid <= 1'b0;
      if (!enable) begin
        // Anything in flight becomes stale: it must be released first.
        if (state != IDLE) state <= WAIT_RELEASE;
        key_held <= 1'b0;
      end else if (scan_done) begin
        case (state)
          IDLE: begin
            if (scan_single) begin
              if (DEBOUNCE_SCANS == 1) begin
                state     <= PRESSED;
                key_code  <= scan_key;
                key_held  <= 1'b1;
                key_valid <= 1'b1;
                scan_cnt  <= '0;
              end else begin
                state    <= DEBOUNCE;
                cand     <= scan_key;
                scan_cnt <= CNT_W'(1);
              end
            end
          end
          DEBOUNCE: begin
            if (scan_empty) begin
              state <= IDLE;
            end else if (!scan_single) begin
              state <= WAIT_RELEASE;
            end else if (scan_key != cand) begin
              cand     <= scan_key;
              scan_cnt <= CNT_W'(1);
            end else if (scan_cnt >= DEB_LAST) begin
              state     <= PRESSED;
              key_code  <= scan_key;
              key_held  <= 1'b1;
              key_valid <= 1'b1;
              scan_cnt  <= '0;
            end else begin
              scan_cnt <= scan_cnt + CNT_W'(1);
            end
          end
          PRESSED: begin
            if (scan_empty) begin
              state    <= IDLE;
              key_held <= 1'b0;
            end else if (!scan_single || scan_key != key_code) begin
              state    <= WAIT_RELEASE;
              key_held <= 1'b0;
            end else begin
`ifdef KEYPAD_REPEAT_EN
              if (scan_cnt >= RPT_LAST) begin
                key_valid <= 1'b1;
                scan_cnt  <= '0;
              end else begin
                scan_cnt <= scan_cnt + CNT_W'(1);
              end
`endif
            end
          end
          WAIT_RELEASE: begin
            if (scan_empty) state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// Testbench for keypad_scanner: directed scan table plus randomized scans
// checked against a scan-level reference model.
module tb_keypad_scanner;

  localparam int SCAN_DIV = 4;
  localparam int DEB      = 3;
  localparam int RPT      = 2;
  localparam int SCAN_CYC = 4 * SCAN_DIV;

`ifdef KEYPAD_REPEAT_EN
  localparam bit RPT_ON = 1'b1;
`else
  localparam bit RPT_ON = 1'b0;
`endif

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       enable = 1'b0;
  logic [3:0] keypadCol = 4'hF;
  logic [3:0] keypadRow;
  logic       key_valid;
  logic [3:0] key_code;
  logic       key_held;

  keypad_scanner #(
    .SCAN_DIV(SCAN_DIV),
    .DEBOUNCE_SCANS(DEB),
    .REPEAT_SCANS(RPT)
  ) dut (
    .clock(clock),
    .reset(reset),
    .enable(enable),
    .keypadCol(keypadCol),
    .keypadRow(keypadRow),
    .key_valid(key_valid),
    .key_code(key_code),
    .key_held(key_held)
  );

  always #5 clock = ~clock;

  int n_pass = 0;
  int n_total = 0;

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  function automatic logic [15:0] key(input int n);
    logic [15:0] m;
    m = 16'd1 << n;
    return m;
  endfunction

  // Physical keypad: a pressed key pulls its column low while its row is strobed.
  function automatic logic [3:0] col_for(input logic [3:0] row, input logic [15:0] m);
    logic [3:0] c;
    c = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int k = 0; k < 4; k++)
        if (!row[r] && m[r*4+k]) c[k] = 1'b0;
    return c;
  endfunction

  // Runs n cycles aligned to a scan start; counts key_valid pulses and row-order errors.
  task automatic run_cycles(input int n, input logic [15:0] m, input bit en,
                            output int vcnt, output bit vlast, output int rerr);
    logic [3:0] exp_row;
    vcnt = 0;
    vlast = 1'b0;
    rerr = 0;
    for (int j = 0; j < n; j++) begin
      enable = en;
      keypadCol = col_for(keypadRow, m);
      @(posedge clock);
      #1;
      if (key_valid) vcnt++;
      vlast = key_valid;
      exp_row = 4'hF ^ (4'b0001 << (((j + 1) / SCAN_DIV) % 4));
      if (keypadRow != exp_row) rerr++;
      @(negedge clock);
    end
  endtask

  task automatic scan_and_check(input string tag, input logic [15:0] m, input bit en,
                                input bit ev, input int ecode, input bit eheld);
    int vc, re;
    bit vl;
    run_cycles(SCAN_CYC, m, en, vc, vl, re);
    check({tag, "_valid_count"}, vc, int'(ev));
    check({tag, "_valid_at_tick"}, int'(vl), int'(ev));
    check({tag, "_code"}, int'(key_code), ecode);
    check({tag, "_held"}, int'(key_held), int'(eheld));
    check({tag, "_row_errors"}, re, 0);
  endtask

  // Directed scan table.
  typedef struct {
    logic [15:0] mask;
    bit          en;
    bit          valid;
    int          code;
    bit          held;
  } vec_t;
  vec_t tbl[$];

  task automatic add(input int reps, input logic [15:0] m, input bit en,
                     input bit v, input int code, input bit held);
    vec_t e;
    e.mask = m; e.en = en; e.valid = v; e.code = code; e.held = held;
    for (int i = 0; i < reps; i++) tbl.push_back(e);
  endtask

  // Scan-level reference model.
  localparam int S_IDLE = 0, S_DEB = 1, S_PR = 2, S_WR = 3;
  int m_st, m_cand, m_cnt, m_code, m_rc;
  bit m_pulse;

  task automatic model_reset();
    m_st = S_IDLE; m_cand = 0; m_cnt = 0; m_code = 0; m_rc = 0; m_pulse = 1'b0;
  endtask

  task automatic model_accept(input int k);
    m_st = S_PR; m_code = k; m_pulse = 1'b1; m_rc = 0;
  endtask

  task automatic model_scan(input logic [15:0] m, input bit en);
    int n, k;
    n = $countones(m);
    k = 0;
    for (int i = 0; i < 16; i++) if (m[i]) k = i;
    m_pulse = 1'b0;
    if (!en) begin
      if (m_st != S_IDLE) m_st = S_WR;
    end else begin
      case (m_st)
        S_IDLE:
          if (n == 1) begin
            if (DEB == 1) model_accept(k);
            else begin m_st = S_DEB; m_cand = k; m_cnt = 1; end
          end
        S_DEB:
          if (n == 0) m_st = S_IDLE;
          else if (n > 1) m_st = S_WR;
          else if (k != m_cand) begin m_cand = k; m_cnt = 1; end
          else begin
            m_cnt++;
            if (m_cnt >= DEB) model_accept(k);
          end
        S_PR:
          if (n == 0) m_st = S_IDLE;
          else if (n > 1 || k != m_code) m_st = S_WR;
          else if (RPT_ON) begin
            m_rc++;
            if (m_rc >= RPT) begin m_pulse = 1'b1; m_rc = 0; end
          end
        default:
          if (n == 0) m_st = S_IDLE;
      endcase
    end
  endtask

  initial begin
    int vc, re;
    bit vl;
    int fav, a, b, sel;
    logic [15:0] m;
    bit en;

    // Press 9 for 5 scans, then release.
    add(2, key(9), 1, 0, 0, 0);
    add(1, key(9), 1, 1, 9, 1);
    add(1, key(9), 1, 0, 9, 1);
    add(1, key(9), 1, RPT_ON, 9, 1);
    add(1, 16'h0,  1, 0, 9, 0);
    // Bounce after two scans restarts the debounce.
    add(2, key(9), 1, 0, 9, 0);
    add(1, 16'h0,  1, 0, 9, 0);
    add(2, key(9), 1, 0, 9, 0);
    add(1, key(9), 1, 1, 9, 1);
    add(1, 16'h0,  1, 0, 9, 0);
    // Ghost press: key 0 alone must be released and re-pressed.
    add(1, key(0), 1, 0, 9, 0);
    add(6, key(0) | key(15), 1, 0, 9, 0);
    add(3, key(0), 1, 0, 9, 0);
    add(1, 16'h0,  1, 0, 9, 0);
    add(2, key(0), 1, 0, 9, 0);
    add(1, key(0), 1, 1, 0, 1);
    add(1, 16'h0,  1, 0, 0, 0);
    // Key held across a disabled window is not reported.
    add(1, key(9), 1, 0, 0, 0);
    add(2, key(9), 0, 0, 0, 0);
    add(3, key(9), 1, 0, 0, 0);
    add(1, 16'h0,  1, 0, 0, 0);
    add(2, key(9), 1, 0, 0, 0);
    add(1, key(9), 1, 1, 9, 1);
    add(1, key(9), 0, 0, 9, 0);
    add(1, key(9), 1, 0, 9, 0);
    add(1, 16'h0,  1, 0, 9, 0);
    // Different key while pressed goes to release wait.
    add(2, key(5), 1, 0, 9, 0);
    add(1, key(5), 1, 1, 5, 1);
    add(1, key(6), 1, 0, 5, 0);
    add(1, key(5), 1, 0, 5, 0);
    add(1, 16'h0,  1, 0, 5, 0);
    // Different key during debounce restarts with the new candidate.
    add(1, key(3),  1, 0, 5, 0);
    add(2, key(12), 1, 0, 5, 0);
    add(1, key(12), 1, 1, 12, 1);
    add(1, 16'h0,   1, 0, 12, 0);
    // Key 5 held for 9 scans (auto-repeat when enabled).
    add(2, key(5), 1, 0, 12, 0);
    add(1, key(5), 1, 1, 5, 1);
    for (int i = 0; i < 3; i++) begin
      add(1, key(5), 1, 0, 5, 1);
      add(1, key(5), 1, RPT_ON, 5, 1);
    end

    repeat (3) @(negedge clock);
    check("reset_row", int'(keypadRow), 4'b1110);
    check("reset_valid", int'(key_valid), 0);
    check("reset_code", int'(key_code), 0);
    check("reset_held", int'(key_held), 0);
    reset = 1'b0;

    foreach (tbl[i])
      scan_and_check($sformatf("tbl%0d", i), tbl[i].mask, tbl[i].en,
                     tbl[i].valid, tbl[i].code, tbl[i].held);

    // Asynchronous reset in the middle of a scan while key 5 is held.
    run_cycles(7, key(5), 1'b1, vc, vl, re);
    check("pre_reset_row_errors", re, 0);
    @(posedge clock);
    #2;
    reset = 1'b1;
    #1;
    check("midreset_row", int'(keypadRow), 4'b1110);
    check("midreset_valid", int'(key_valid), 0);
    check("midreset_code", int'(key_code), 0);
    check("midreset_held", int'(key_held), 0);
    @(negedge clock);
    reset = 1'b0;
    model_reset();

    // Randomized scans against the model.
    fav = int'($urandom_range(0, 15));
    for (int s = 0; s < 40; s++) begin
      if ($urandom_range(0, 4) == 0) fav = int'($urandom_range(0, 15));
      sel = int'($urandom_range(0, 9));
      if (sel <= 2) m = 16'h0;
      else if (sel <= 7) m = key(fav);
      else if (sel == 8) m = key(int'($urandom_range(0, 15)));
      else begin
        a = int'($urandom_range(0, 15));
        b = (a + 1 + int'($urandom_range(0, 14))) % 16;
        m = key(a) | key(b);
      end
      en = ($urandom_range(0, 9) != 0);
      model_scan(m, en);
      scan_and_check($sformatf("rnd%0d", s), m, en, m_pulse, m_code, m_st == S_PR);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
